// File: rtl/brpred_pkg.sv
// rtl/brpred_pkg.sv - counter states, branch funct3 codes and defaults for the branch predictor
package brpred_pkg;

  localparam int IDX_W_DEF = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic cnt_state_e cnt_next(input cnt_state_e s, input logic taken);
    case (s)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      default: return taken ? ST  : WT;
    endcase
  endfunction

endpackage

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - maps branch funct3 and comparator flags to the actual outcome
module br_resolve
  import brpred_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_less_i,
  input  logic       br_equal_i,
  output logic       taken_o,
  output logic       legal_o
);

  // Signedness is resolved upstream, so BLT/BLTU and BGE/BGEU share a flag.
  always_comb begin
    taken_o = 1'b0;
    legal_o = 1'b1;
    case (funct3_i)
      F3_BEQ:           taken_o = br_equal_i;
      F3_BNE:           taken_o = !br_equal_i;
      F3_BLT, F3_BLTU:  taken_o = br_less_i;
      F3_BGE, F3_BGEU:  taken_o = !br_less_i;
      default:          legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal 2-bit branch predictor; BRPRED_STATS_EN adds branch/mispredict counters
module branch_predictor
  import brpred_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  output logic        pred_taken_o,
  input  logic        res_valid_i,
  input  logic [31:0] res_pc_i,
  input  logic [2:0]  res_funct3_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  input  logic        res_pred_taken_i,
  output logic        res_taken_o,
  output logic        mispredict_o
`ifdef BRPRED_STATS_EN
  ,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  cnt_state_e       table_q [ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       pred_cnt;
  logic             res_taken;
  logic             res_legal;
  logic             accept;
  logic             miss;
  logic             unused_pc;

  // Only the word-aligned index bits matter; the rest alias freely.
  assign pred_idx  = pc_i[IDX_W+1:2];
  assign res_idx   = res_pc_i[IDX_W+1:2];
  assign unused_pc = ^{pc_i[31:IDX_W+2], pc_i[1:0], res_pc_i[31:IDX_W+2], res_pc_i[1:0]};

  br_resolve u_resolve (
    .funct3_i   (res_funct3_i),
    .br_less_i  (br_less_i),
    .br_equal_i (br_equal_i),
    .taken_o    (res_taken),
    .legal_o    (res_legal)
  );

  assign accept = res_valid_i && res_legal;
  assign miss   = res_taken ^ res_pred_taken_i;

  // Read port sees the pre-update value when it collides with the write port.
  assign pred_cnt     = table_q[pred_idx];
  assign pred_taken_o = pred_cnt[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= WNT;
      end
    end else if (accept) begin
      table_q[res_idx] <= cnt_next(table_q[res_idx], res_taken);
    end
  end

  // An illegal funct3 still reports a (forced not-taken) outcome.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_taken_o  <= 1'b0;
      mispredict_o <= 1'b0;
    end else begin
      mispredict_o <= accept && miss;
      if (res_valid_i) begin
        res_taken_o <= accept && res_taken;
      end
    end
  end

`ifdef BRPRED_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (accept && (br_cnt_o != '1)) begin
        br_cnt_o <= br_cnt_o + 32'd1;
      end
      if (accept && miss && (mispred_cnt_o != '1)) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end
`endif

  a_mispredict_has_cause: assert property (
    @(posedge clk_i) disable iff (!rst_ni) mispredict_o |-> $past(accept)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - vector-table and scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic [2:0]  res_funct3_i;
  logic        br_less_i;
  logic        br_equal_i;
  logic        res_pred_taken_i;
  logic        res_taken_o;
  logic        mispredict_o;
`ifdef BRPRED_STATS_EN
  logic [31:0] br_cnt_o;
  logic [31:0] mispred_cnt_o;
`endif

  branch_predictor #(.IDX_W(6)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .pc_i             (pc_i),
    .pred_taken_o     (pred_taken_o),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_funct3_i     (res_funct3_i),
    .br_less_i        (br_less_i),
    .br_equal_i       (br_equal_i),
    .res_pred_taken_i (res_pred_taken_i),
    .res_taken_o      (res_taken_o),
    .mispredict_o     (mispredict_o)
`ifdef BRPRED_STATS_EN
    ,
    .br_cnt_o         (br_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic        less;
    logic        eq;
    logic        pt;
    logic        exp_pred;
    logic        exp_taken;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    string name;
    logic  taken;
    logic  mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_br   = 0;
  int   exp_mis  = 0;

  function automatic vec_t mk(logic vld, logic [31:0] pc, logic [2:0] f3, logic less, logic eq,
                              logic pt, logic ep, logic et, logic em);
    vec_t v;
    v.vld = vld; v.pc = pc; v.f3 = f3; v.less = less; v.eq = eq; v.pt = pt;
    v.exp_pred = ep; v.exp_taken = et; v.exp_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    logic legal;
    @(negedge clk_i);
    res_valid_i      = v.vld;
    res_pc_i         = v.pc;
    pc_i             = v.pc;
    res_funct3_i     = v.f3;
    br_less_i        = v.less;
    br_equal_i       = v.eq;
    res_pred_taken_i = v.pt;
    #1;
    check({tag, ".pred"}, pred_taken_o, v.exp_pred);
    legal = (v.f3 != 3'b010) && (v.f3 != 3'b011);
    if (v.vld && legal) exp_br++;
    if (v.exp_mis) exp_mis++;
    sb.push_back('{tag, v.exp_taken, v.exp_mis});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check({e.name, ".res_taken"}, res_taken_o, e.taken);
    check({e.name, ".mispredict"}, mispredict_o, e.mis);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; pc_i = 32'h40; res_valid_i = 1'b0; res_pc_i = 32'h0;
    res_funct3_i = 3'b000; br_less_i = 1'b0; br_equal_i = 1'b0; res_pred_taken_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset.pred", pred_taken_o, 1'b0);
    check("reset.res_taken", res_taken_o, 1'b0);
    check("reset.mispredict", mispredict_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //           vld pc            f3      lt eq pt  pred tk mis
    vecs.push_back(mk(0, 32'h40,        3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h40,        3'b000, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 32'h40,        3'b000, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 32'h40,        3'b000, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 32'h40,        3'b000, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h80,        3'b101, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 32'h80,        3'b011, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h80,        3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h80,        3'b001, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 32'h80,        3'b100, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 32'h80,        3'b110, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 32'h80,        3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000_0080, 3'b111, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 32'h80,        3'b000, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h80,        3'b010, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'h80,        3'b000, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 32'h80,        3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h80,        3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h80,        3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h40,        3'b000, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 32'h40,        3'b001, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 32'h40,        3'b000, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 32'h40,        3'b000, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h40,        3'b000, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 32'h40,        3'b000, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

`ifdef BRPRED_STATS_EN
    check("stats.br_cnt", br_cnt_o, exp_br);
    check("stats.mispred_cnt", mispred_cnt_o, exp_mis);
`endif

    // Train 0x40 from WNT to ST, then reset asynchronously with a resolve in flight.
    apply(mk(1, 32'h40, 3'b000, 0, 1, 0, 0, 1, 1), "train0");
    apply(mk(1, 32'h40, 3'b000, 0, 1, 1, 1, 1, 0), "train1");
    apply(mk(0, 32'h40, 3'b000, 0, 0, 0, 1, 1, 0), "train2");
    @(negedge clk_i);
    res_valid_i = 1'b1; res_pc_i = 32'h40; pc_i = 32'h40;
    res_funct3_i = 3'b000; br_equal_i = 1'b1; res_pred_taken_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst.pred", pred_taken_o, 1'b0);
    check("arst.res_taken", res_taken_o, 1'b0);
    check("arst.mispredict", mispredict_o, 1'b0);
`ifdef BRPRED_STATS_EN
    check("arst.br_cnt", br_cnt_o, 32'd0);
    check("arst.mispred_cnt", mispred_cnt_o, 32'd0);
`endif
    @(posedge clk_i);
    #1;
    check("arst.hold_pred", pred_taken_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("arst.release_pred", pred_taken_o, 1'b0);
    @(posedge clk_i);
    #1;
    check("arst.first_update_pred", pred_taken_o, 1'b1);
    check("arst.first_update_taken", res_taken_o, 1'b1);
    check("arst.first_update_mis", mispredict_o, 1'b1);
    @(negedge clk_i);
    res_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("arst.pulse_end", mispredict_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
